// File: rtl/memory_pkg.sv
// memory_pkg: instruction-memory sizing and loader FSM state encoding
package memory_pkg;
  localparam int INSTR_MEM_SIZE_WORDS = 256;
  localparam int INSTR_MEM_SIZE_BYTES = INSTR_MEM_SIZE_WORDS * 4;
  localparam int LOADER_HDR_BYTES = 4;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} loader_state_e;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: gathers 4 bytes into a little-endian word
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : drop any partial word
//   push_i/data_i : accept one byte
//   word_o        : word including the byte being pushed now
//   last_o        : this push completes a 4-byte group
module byte_word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        last_o
);
  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  // shifting in from the top leaves byte 0 in bits [7:0] after four pushes
  assign word_o = {data_i, sr_q[31:8]};
  assign last_o = push_i && cnt_q == 2'd3;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (push_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= word_o;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte stream (LE count N, then N LE words) -> instruction RAM writes
//   clk_i, rst_ni                     : clock, synchronous active-low reset
//   start_i                           : begin session (IDLE/ERR only)
//   byte_valid_i/byte_data_i/byte_ready_o : byte stream handshake
//   mem_we_o/mem_addr_o/mem_wdata_o   : RAM write port, one pulse per word
//   busy_o, core_rst_o, done_o, err_o : session status
module instr_mem_loader
  import memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = INSTR_MEM_SIZE_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  loader_state_e state_q;
  logic [31:0]   len_q, addr_q, wdata_q, word;
  logic [IW-1:0] idx_q;
  logic          push, clear, last;
  assign byte_ready_o = state_q == LEN || state_q == DATA;
  assign mem_we_o     = state_q == WRITE;
  assign busy_o       = state_q == LEN || state_q == DATA || state_q == WRITE;
  assign core_rst_o   = state_q != IDLE;
  assign done_o       = state_q == DONE;
  assign err_o        = state_q == ERR;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign push  = byte_valid_i && byte_ready_o;
  assign clear = start_i && (state_q == IDLE || state_q == ERR);
  byte_word_packer u_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear),
    .push_i (push),
    .data_i (byte_data_i),
    .word_o (word),
    .last_o (last)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, ERR: if (start_i) begin
          state_q <= LEN;
          len_q   <= '0;
          idx_q   <= '0;
        end
        LEN: if (last) begin
          len_q   <= word;
          idx_q   <= '0;
          // full 32-bit compare so an oversize count is rejected, never wrapped
          state_q <= word == 32'd0 ? DONE : word > 32'(MAX_WORDS) ? ERR : DATA;
        end
        DATA: if (last) begin
          wdata_q <= word;
          addr_q  <= BASE_ADDR + 32'({idx_q, 2'b00});
          state_q <= WRITE;
        end
        WRITE: begin
          state_q <= 32'(idx_q) == len_q - 32'd1 ? DONE : DATA;
          idx_q   <= idx_q + 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;
  import memory_pkg::*;
  localparam int MAXW = INSTR_MEM_SIZE_WORDS;
  logic clk = 0, rst_n = 0, start = 0, bv = 0;
  logic [7:0] bd = 0;
  logic ready, we, busy, core_rst, done, err;
  logic [31:0] addr, wdata;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t e_w;
  int exp_done = 0;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] words[$];

  instr_mem_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_valid_i(bv), .byte_data_i(bd),
    .byte_ready_o(ready), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .busy_o(busy), .core_rst_o(core_rst), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (we) begin
      chk("write_expected", 32'(exp_q.size() > 0), 1);
      chk("core_rst_in_write", 32'(core_rst), 1);
      if (exp_q.size() > 0) begin
        e_w = exp_q.pop_front();
        chk("wr_addr", addr, e_w.a);
        chk("wr_data", wdata, e_w.d);
      end
    end
    if (done) begin
      chk("done_expected", 32'(exp_done > 0), 1);
      if (exp_done > 0) exp_done--;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      bv = 0;
      bd = 8'($urandom);
    end
    @(negedge clk);
    bv = 1;
    bd = b;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("byte_ready_timeout", 32'(ready), 1);
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bv = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    @(negedge clk);
    bv = 0;
    while ((exp_q.size() > 0 || exp_done > 0 || busy || done) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drained"}, 32'(t < 300), 1);
  endtask

  // n: header count; rst_at >= 0 resets after that many payload bytes
  task automatic run_session(input string nm, input logic [31:0] n, input bit gaps,
                             input bit mid_start, input int rst_at);
    logic [31:0] w;
    pulse_start();
    chk({nm, "_core_rst_on"}, 32'(core_rst), 1);
    chk({nm, "_busy_on"}, 32'(busy), 1);
    chk({nm, "_err_clear"}, 32'(err), 0);
    if (n <= 32'(MAXW)) begin
      while (words.size() < int'(n)) words.push_back($urandom);
      if (rst_at < 0) begin
        for (int i = 0; i < int'(n); i++) exp_q.push_back('{32'(i * 4), words[i]});
        exp_done++;
      end
    end
    for (int k = 0; k < 4; k++) send_byte(n[8*k+:8], gaps);
    if (n > 32'(MAXW)) begin
      @(negedge clk);
      bv = 0;
      repeat (3) @(negedge clk);
      chk({nm, "_err"}, 32'(err), 1);
      chk({nm, "_err_core_rst"}, 32'(core_rst), 1);
      chk({nm, "_err_ready"}, 32'(ready), 0);
      chk({nm, "_err_busy"}, 32'(busy), 0);
      return;
    end
    for (int j = 0; j < int'(n) * 4; j++) begin
      if (j == rst_at) begin
        @(negedge clk);
        bv = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk({nm, "_rst_busy"}, 32'(busy), 0);
        chk({nm, "_rst_core_rst"}, 32'(core_rst), 0);
        chk({nm, "_rst_ready"}, 32'(ready), 0);
        repeat (8) @(negedge clk);
        chk({nm, "_rst_idle"}, 32'(core_rst), 0);
        words.delete();
        return;
      end
      if (mid_start && j == 2) pulse_start();
      w = words[j/4];
      send_byte(w[8*(j%4)+:8], gaps);
    end
    wait_drain(nm);
    chk({nm, "_core_rst_off"}, 32'(core_rst), 0);
    chk({nm, "_err_off"}, 32'(err), 0);
    words.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bv = 1;
    bd = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_core_rst", 32'(core_rst), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    bv = 0;
    rst_n = 1;
    @(negedge clk);
    words.push_back(32'h0010_0513);
    run_session("single", 1, 0, 0, -1);
    run_session("gaps", 3, 1, 0, -1);
    run_session("oversize", 32'(MAXW + 1), 0, 0, -1);
    run_session("after_err", 1, 0, 0, -1);
    run_session("zero", 0, 0, 0, -1);
    run_session("reset_mid", 2, 0, 0, 2);
    run_session("start_mid", 2, 0, 1, -1);
    for (int r = 0; r < 4; r++) run_session("random", 32'($urandom_range(1, 6)), 1, 0, -1);
    run_session("full", 32'(MAXW), 0, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
